// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Groups every non-clock signal of the instruction fetch unit.
//   Control-unit side : fetch_en, pc_write, pc_src, reg_target (in),
//                       ir_valid, decoded IR fields, pc, addr_err, proto_err (out)
//   Memory side       : imem_req, imem_addr (out), imem_ack, imem_rdata (in)
//   modport master : the fetch unit
//   modport slave  : control unit + instruction memory (or a bench)
interface instr_fetch_unit_if;
  logic        fetch_en;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [31:0] reg_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [5:0]  funcfield;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] pc;
  logic        addr_err;
  logic        proto_err;

  modport master (
    input  fetch_en, pc_write, pc_src, reg_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir_valid, opcode, funcfield, rs, rt, rd, shamt,
           imm, jtarget, pc, addr_err, proto_err
  );

  modport slave (
    output fetch_en, pc_write, pc_src, reg_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir_valid, opcode, funcfield, rs, rt, rd, shamt,
           imm, jtarget, pc, addr_err, proto_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Holds the PC, fetches 32-bit instructions over a req/ack handshake into
//   the IR, decodes IR fields for the control unit and applies the PC update
//   (hold / branch / jump / register) selected by the control unit.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_unit_if.master (control, memory and decode signals)
// Params
//   RESET_PC : word-aligned PC value loaded on reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_addr_err;
  logic        r_proto_err;

  logic        w_in_req;
  logic        w_misalign;
  logic [31:0] w_br_off;
  logic [31:0] w_pc_upd;

  assign w_in_req   = (r_state == REQ);
  assign w_misalign = (bus.reg_target[1:0] != 2'b00);
  // pc already points past the fetched word, so the branch base is pc itself
  assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_pc_upd = r_pc;
    case (bus.pc_src)
      2'b01:   w_pc_upd = r_pc + w_br_off;
      2'b10:   w_pc_upd = {r_pc[31:28], r_ir[25:0], 2'b00};
      2'b11:   w_pc_upd = w_misalign ? r_pc : bus.reg_target;
      default: w_pc_upd = r_pc;
    endcase
  end

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // ---- FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = REQ;
      REQ:     if (bus.imem_ack) w_state_nxt = HOLD;
      HOLD:    if (bus.fetch_en) w_state_nxt = REQ;
      default: w_state_nxt = BOOT;
    endcase
  end

  // ---- FSM: outputs (decoded from state only, no input->output path)
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_valid = 1'b0;
    case (r_state)
      REQ:     bus.imem_req = 1'b1;
      HOLD:    bus.ir_valid = 1'b1;
      default: ;
    endcase
  end

  // ---- PC / IR / error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_addr_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_addr_err  <= 1'b0;
      // control requests while a fetch is outstanding are dropped, but flagged
      r_proto_err <= w_in_req & (bus.fetch_en | bus.pc_write);
      if (w_in_req) begin
        if (bus.imem_ack) begin
          r_ir <= bus.imem_rdata;
          r_pc <= r_pc + 32'd4;
        end
      end else if (bus.pc_write) begin
        // BOOT and HOLD both accept PC updates; the following REQ sees the new PC
        r_pc       <= w_pc_upd;
        r_addr_err <= (bus.pc_src == 2'b11) & w_misalign;
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.addr_err  = r_addr_err;
  assign bus.proto_err = r_proto_err;
  assign bus.opcode    = r_ir[31:26];
  assign bus.rs        = r_ir[25:21];
  assign bus.rt        = r_ir[20:16];
  assign bus.rd        = r_ir[15:11];
  assign bus.shamt     = r_ir[10:6];
  assign bus.funcfield = r_ir[5:0];
  assign bus.imm       = r_ir[15:0];
  assign bus.jtarget   = r_ir[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // model state: expected PC and IR contents
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en = 0; bus.pc_write = 0; bus.pc_src = 0; bus.reg_target = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0;
  endtask

  // PC update rules expressed as plain arithmetic on integers
  function automatic logic [31:0] model_pc(input logic [31:0] pc, input logic [31:0] ir,
                                           input logic [1:0] src, input logic [31:0] rt);
    case (src)
      2'd1:    return pc + 32'(int'($signed(ir[15:0])) * 4);
      2'd2:    return (pc & 32'hF000_0000) + (32'(ir[25:0]) * 4);
      2'd3:    return (rt % 4 == 0) ? rt : pc;
      default: return pc;
    endcase
  endfunction

  // stimulus only: issue a PC write from HOLD (no fetch)
  task automatic pc_update(input logic [1:0] src, input logic [31:0] rt);
    bus.pc_write = 1; bus.pc_src = src; bus.reg_target = rt;
    tick();
    bus.pc_write = 0; bus.pc_src = 0;
  endtask

  // stimulus only: fetch from HOLD with zero wait states
  task automatic fetch(input logic [31:0] data);
    bus.fetch_en = 1; tick(); bus.fetch_en = 0;
    bus.imem_ack = 1; bus.imem_rdata = data; tick(); bus.imem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.imem_req, bus.ir_valid, bus.addr_err, bus.proto_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {bus.imem_req, bus.ir_valid, bus.addr_err, bus.proto_err});
    end
    checks++;
    if ({bus.pc, bus.opcode, bus.funcfield} !== 44'h0) begin
      errors++; $display("FAIL reset_pc_ir: pc %h op %b fn %b exp zero", bus.pc, bus.opcode, bus.funcfield);
    end
    rst_n = 1;
    tick();  // BOOT -> REQ
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL boot_req: req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1; bus.imem_rdata = 32'h2010_0005;
    tick(); bus.imem_ack = 0;
    checks++;
    if (bus.ir_valid !== 1'b1 || bus.opcode !== 6'b001000 || bus.imm !== 16'h0005 || bus.pc !== 32'h4) begin
      errors++; $display("FAIL boot_fetch: v %b op %b imm %h pc %h exp 1 001000 0005 00000004", bus.ir_valid, bus.opcode, bus.imm, bus.pc);
    end
  endtask

  task automatic test_wait_states();
    bus.fetch_en = 1; tick(); bus.fetch_en = 0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.ir_valid !== 1'b0) begin
        errors++; $display("FAIL wait_cycle%0d: req %b addr %h v %b exp 1 00000004 0", w, bus.imem_req, bus.imem_addr, bus.ir_valid);
      end
      if (w == 3) begin bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0020; end
      tick();
    end
    bus.imem_ack = 0;
    checks++;
    if (bus.funcfield !== 6'b100000 || bus.opcode !== 6'd0 || bus.pc !== 32'h8 || bus.ir_valid !== 1'b1) begin
      errors++; $display("FAIL wait_data: fn %b op %b pc %h v %b exp 100000 0 00000008 1", bus.funcfield, bus.opcode, bus.pc, bus.ir_valid);
    end
  endtask

  task automatic test_branch();
    fetch(32'h0000_0000);   // pc 8 -> C
    fetch(32'h1000_FFFF);   // pc C -> 10, imm = -1
    checks++;
    if (bus.pc !== 32'h10 || bus.imm !== 16'hFFFF) begin
      errors++; $display("FAIL branch_setup: pc %h imm %h exp 00000010 ffff", bus.pc, bus.imm);
    end
    bus.pc_write = 1; bus.pc_src = 2'b01; bus.fetch_en = 1;
    tick();
    bus.pc_write = 0; bus.pc_src = 0; bus.fetch_en = 0;
    checks++;
    if (bus.pc !== 32'hC || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      errors++; $display("FAIL branch_pc: pc %h req %b addr %h exp 0000000c 1 0000000c", bus.pc, bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0000; tick(); bus.imem_ack = 0;
  endtask

  task automatic test_jump_jr();
    pc_update(2'b11, 32'h4000_0004);
    fetch(32'h0800_0100);   // j, jtarget 0x100; pc -> 4000_0008
    checks++;
    if (bus.pc !== 32'h4000_0008 || bus.jtarget !== 26'h100) begin
      errors++; $display("FAIL jump_setup: pc %h jt %h exp 40000008 100", bus.pc, bus.jtarget);
    end
    pc_update(2'b10, 32'h0);
    checks++;
    if (bus.pc !== 32'h4000_0400) begin
      errors++; $display("FAIL jump_pc: got %h exp 40000400", bus.pc);
    end
    pc_update(2'b11, 32'h0000_0102);
    checks++;
    if (bus.addr_err !== 1'b1 || bus.pc !== 32'h4000_0400) begin
      errors++; $display("FAIL jr_misalign: err %b pc %h exp 1 40000400", bus.addr_err, bus.pc);
    end
    tick();
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++; $display("FAIL jr_err_pulse: got %b exp 0", bus.addr_err);
    end
    pc_update(2'b11, 32'h0000_0100);
    checks++;
    if (bus.pc !== 32'h100 || bus.addr_err !== 1'b0) begin
      errors++; $display("FAIL jr_pc: pc %h err %b exp 00000100 0", bus.pc, bus.addr_err);
    end
  endtask

  task automatic test_proto_err();
    bus.fetch_en = 1; tick(); bus.fetch_en = 0;
    tick();   // one stalled cycle
    bus.fetch_en = 1; bus.pc_write = 1; bus.pc_src = 2'b11; bus.reg_target = 32'h800;
    tick();
    bus.fetch_en = 0; bus.pc_write = 0; bus.pc_src = 0;
    checks++;
    if (bus.proto_err !== 1'b1 || bus.pc !== 32'h100 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL proto_flag: perr %b pc %h addr %h req %b exp 1 00000100 00000100 1", bus.proto_err, bus.pc, bus.imem_addr, bus.imem_req);
    end
    bus.imem_ack = 1; bus.imem_rdata = 32'h0123_4567; tick(); bus.imem_ack = 0;
    checks++;
    if (bus.proto_err !== 1'b0 || bus.ir_valid !== 1'b1 || bus.pc !== 32'h104) begin
      errors++; $display("FAIL proto_fetch: perr %b v %b pc %h exp 0 1 00000104", bus.proto_err, bus.ir_valid, bus.pc);
    end
    repeat (3) begin
      tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b1 || bus.pc !== 32'h104) begin
        errors++; $display("FAIL proto_single: req %b v %b pc %h exp 0 1 00000104", bus.imem_req, bus.ir_valid, bus.pc);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    pc_update(2'b11, 32'h20);
    bus.fetch_en = 1; tick(); bus.fetch_en = 0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
      errors++; $display("FAIL midrst_setup: req %b addr %h exp 1 00000020", bus.imem_req, bus.imem_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0 || bus.ir_valid !== 1'b0 || bus.opcode !== 6'd0) begin
      errors++; $display("FAIL midrst_async: req %b pc %h v %b op %b exp 0 0 0 0", bus.imem_req, bus.pc, bus.ir_valid, bus.opcode);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_refetch: req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1; bus.imem_rdata = 32'hCAFE_0004; tick(); bus.imem_ack = 0;
    m_pc = 32'h4; m_ir = 32'hCAFE_0004;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic        pw, fe, poke, exp_ae;
      logic [1:0]  src;
      logic [31:0] rt, data;
      int          waits;
      pw = 1'($urandom_range(0, 1)); fe = 1'($urandom_range(0, 1));
      src = 2'($urandom_range(0, 3)); rt = $urandom;
      if ($urandom_range(0, 1) == 1) rt = rt & 32'hFFFF_FFFC;
      waits = $urandom_range(0, 3); poke = (waits > 0) && ($urandom_range(0, 1) == 1);
      data = $urandom;
      exp_ae = pw && src == 2'd3 && (rt % 4 != 0);
      if (pw) m_pc = model_pc(m_pc, m_ir, src, rt);
      bus.pc_write = pw; bus.pc_src = src; bus.reg_target = rt; bus.fetch_en = fe;
      tick();
      bus.pc_write = 0; bus.pc_src = 0; bus.fetch_en = 0;
      checks++;
      if (bus.pc !== m_pc || bus.addr_err !== exp_ae) begin
        errors++; $display("FAIL rnd_update[%0d]: pc %h err %b exp %h %b", it, bus.pc, bus.addr_err, m_pc, exp_ae);
      end
      if (!fe) begin bus.fetch_en = 1; tick(); bus.fetch_en = 0; end
      for (int w = 0; w <= waits; w++) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.ir_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_req[%0d.%0d]: req %b addr %h v %b exp 1 %h 0", it, w, bus.imem_req, bus.imem_addr, bus.ir_valid, m_pc);
        end
        if (w == waits) begin bus.imem_ack = 1; bus.imem_rdata = data; end
        else if (w == 0 && poke) begin bus.fetch_en = 1; bus.pc_write = 1; bus.pc_src = 2'd3; bus.reg_target = 32'h40; end
        tick();
        bus.fetch_en = 0; bus.pc_write = 0; bus.pc_src = 0;
        if (w == 0 && poke) begin
          checks++;
          if (bus.proto_err !== 1'b1) begin
            errors++; $display("FAIL rnd_proto[%0d]: got %b exp 1", it, bus.proto_err);
          end
        end
      end
      bus.imem_ack = 0;
      m_ir = data; m_pc = m_pc + 32'd4;
      checks++;
      if (bus.ir_valid !== 1'b1 || bus.pc !== m_pc ||
          {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funcfield} !== m_ir ||
          bus.imm !== m_ir[15:0] || bus.jtarget !== m_ir[25:0]) begin
        errors++; $display("FAIL rnd_fetch[%0d]: v %b pc %h ir %h exp 1 %h %h", it, bus.ir_valid, bus.pc,
                           {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funcfield}, m_pc, m_ir);
      end
    end
  endtask

  initial begin
    m_pc = 0; m_ir = 0;
    test_reset();
    test_wait_states();
    test_branch();
    test_jump_jr();
    test_proto_err();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
